// File: rtl/parser_segs_dispatch_if.sv
// Collector-to-dispatcher and dispatcher-to-engine signal bundle.
// master = collector/engine side, slave = dispatcher.
interface parser_segs_dispatch_if #(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_SEGS         = 2,
    parameter int C_NUM_PARSERS      = 2,
    parameter int C_TAG_WIDTH        = 8
);
    logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] segs_in;
    logic [C_AXIS_TUSER_WIDTH-1:0]           tuser_in;
    logic                                    segs_valid_in;
    logic [C_NUM_PARSERS-1:0]                parser_busy;
    logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] parser_segs;
    logic [C_AXIS_TUSER_WIDTH-1:0]           parser_tuser;
    logic [C_TAG_WIDTH-1:0]                  parser_tag;
    logic [C_NUM_PARSERS-1:0]                parser_valid;

    modport master (
        output segs_in, tuser_in, segs_valid_in, parser_busy,
        input  parser_segs, parser_tuser, parser_tag, parser_valid
    );
    modport slave (
        input  segs_in, tuser_in, segs_valid_in, parser_busy,
        output parser_segs, parser_tuser, parser_tag, parser_valid
    );
endinterface

// File: rtl/parser_segs_dispatch.sv
// Buffers header-segment bundles and hands them round-robin to idle parser
// engines, tagging each dispatch with a sequence number.

// Per-engine eligibility: masks the engine for the cycle after its grant,
// before its own busy flag has had a chance to rise.
module parser_segs_dispatch_lane (
    input  logic axis_clk,
    input  logic aresetn,
    input  logic busy_i,
    input  logic grant_i,
    output logic elig_o
);
    logic holdoff_q;

    always_ff @(posedge axis_clk) begin
        if (!aresetn) holdoff_q <= 1'b0;
        else          holdoff_q <= grant_i;
    end

    assign elig_o = !busy_i && !holdoff_q;
endmodule

module parser_segs_dispatch #(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_SEGS         = 2,
    parameter int C_NUM_PARSERS      = 2,
    parameter int C_FIFO_DEPTH       = 4,
    parameter int C_TAG_WIDTH        = 8
) (
    input  logic                            axis_clk,
    input  logic                            aresetn,
    input  logic                            dispatch_en,
    parser_segs_dispatch_if.slave           bus,
    output logic [$clog2(C_FIFO_DEPTH):0]   fifo_count,
    output logic [31:0]                     drop_cnt
);
    localparam int SW = C_NUM_SEGS * C_AXIS_DATA_WIDTH;
    localparam int TW = C_AXIS_TUSER_WIDTH;
    localparam int BW = SW + TW;
    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int NP = C_NUM_PARSERS;
    localparam int PW = $clog2(C_NUM_PARSERS);

    logic [BW-1:0]          mem_q [C_FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q, count_d;
    logic [31:0]            drop_q, drop_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [C_TAG_WIDTH-1:0] seq_q;
    logic [SW-1:0]          segs_q;
    logic [TW-1:0]          tuser_q;
    logic [C_TAG_WIDTH-1:0] tag_q;
    logic [NP-1:0]          valid_q;

    logic [NP-1:0] elig, grant_oh;
    logic [PW-1:0] grant_idx;
    logic          found, full, push, pop, drop;
    logic [BW-1:0] head;

    for (genvar i = 0; i < NP; i++) begin : g_lane
        parser_segs_dispatch_lane u_lane (
            .axis_clk (axis_clk),
            .aresetn  (aresetn),
            .busy_i   (bus.parser_busy[i]),
            .grant_i  (grant_oh[i]),
            .elig_o   (elig[i])
        );
    end

    // First eligible engine at or after rr_ptr, wrapping at NP.
    always_comb begin
        int unsigned   s;
        logic [PW-1:0] idx;
        s         = 0;
        idx       = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NP; k++) begin
            s = int'(rr_ptr_q) + k;
            if (s >= NP) s = s - NP;
            idx = PW'(s);
            if (!found && elig[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign full = (count_q == CW'(C_FIFO_DEPTH));
    assign pop  = (count_q != '0) && dispatch_en && found;
    // A full FIFO still takes the new bundle when the head leaves this cycle.
    assign push = bus.segs_valid_in && (!full || pop);
    assign drop = bus.segs_valid_in && !push;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        grant_oh = '0;
        if (pop) grant_oh[grant_idx] = 1'b1;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        drop_d = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
        rr_ptr_d = (grant_idx == PW'(NP - 1)) ? '0 : PW'(grant_idx + 1'b1);
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge axis_clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.segs_in, bus.tuser_in};
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            rr_ptr_q <= '0;
            seq_q    <= '0;
            segs_q   <= '0;
            tuser_q  <= '0;
            tag_q    <= '0;
            valid_q  <= '0;
        end else begin
            count_q <= count_d;
            drop_q  <= drop_d;
            valid_q <= grant_oh;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rr_ptr_q <= rr_ptr_d;
                seq_q    <= seq_q + 1'b1;
                segs_q   <= head[BW-1:TW];
                tuser_q  <= head[TW-1:0];
                tag_q    <= seq_q;
            end
        end
    end

    assign bus.parser_segs  = segs_q;
    assign bus.parser_tuser = tuser_q;
    assign bus.parser_tag   = tag_q;
    assign bus.parser_valid = valid_q;
    assign fifo_count       = count_q;
    assign drop_cnt         = drop_q;
endmodule

// File: tb/tb_parser_segs_dispatch.sv
// Randomized scoreboard bench for parser_segs_dispatch against a queue-based
// reference model with reactive engine emulation.
module tb_parser_segs_dispatch;
    localparam int DW = 512, TW = 128, NS = 2, NP = 2, D = 4, TAGW = 8;
    localparam int SW = NS * DW;
    localparam int CW = $clog2(D) + 1;

    typedef struct {
        logic [SW-1:0] segs;
        logic [TW-1:0] tuser;
    } bundle_t;

    typedef struct {
        int              cyc;
        logic [NP-1:0]   grant;
        logic [SW-1:0]   segs;
        logic [TW-1:0]   tuser;
        logic [TAGW-1:0] tag;
    } exp_t;

    logic          axis_clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          dispatch_en = 1'b0;
    logic [CW-1:0] fifo_count;
    logic [31:0]   drop_cnt;

    parser_segs_dispatch_if #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TW),
        .C_NUM_SEGS(NS), .C_NUM_PARSERS(NP), .C_TAG_WIDTH(TAGW)) bus ();

    parser_segs_dispatch #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TW),
        .C_NUM_SEGS(NS), .C_NUM_PARSERS(NP), .C_FIFO_DEPTH(D), .C_TAG_WIDTH(TAGW)) dut (
        .axis_clk    (axis_clk),
        .aresetn     (aresetn),
        .dispatch_en (dispatch_en),
        .bus         (bus.slave),
        .fifo_count  (fifo_count),
        .drop_cnt    (drop_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    int n_cmp = 0, n_err = 0;
    int edge_cnt = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: bundle queue, modulo round-robin, one-cycle holdoff.
    bundle_t       mq[$];
    exp_t          sb[$];
    int            m_rr = 0, m_tag = 0;
    longint        m_drops = 0;
    logic [NP-1:0] m_hold = '0;

    always @(posedge axis_clk) begin
        int      g;
        bit      acc;
        bundle_t nb, hb;
        edge_cnt++;
        if (!aresetn) begin
            mq.delete();
            m_rr = 0; m_tag = 0; m_drops = 0; m_hold = '0;
        end else begin
            g = -1;
            if (mq.size() > 0 && dispatch_en)
                for (int k = 0; k < NP; k++) begin
                    int idx;
                    idx = (m_rr + k) % NP;
                    if (g < 0 && !bus.parser_busy[idx] && !m_hold[idx]) g = idx;
                end
            acc = 1'b0;
            if (bus.segs_valid_in) begin
                if (mq.size() < D || g >= 0) begin
                    acc = 1'b1;
                    nb.segs = bus.segs_in;
                    nb.tuser = bus.tuser_in;
                end else if (m_drops < 64'hFFFF_FFFF) m_drops++;
            end
            if (g >= 0) begin
                hb = mq.pop_front();
                sb.push_back('{edge_cnt, NP'(1) << g, hb.segs, hb.tuser, TAGW'(m_tag)});
                m_tag = (m_tag + 1) % (1 << TAGW);
                m_rr = (g + 1) % NP;
                m_hold = NP'(1) << g;
            end else m_hold = '0;
            if (acc) mq.push_back(nb);
        end
    end

    // Monitor: pops the scoreboard whenever a grant is due or presented.
    always @(negedge axis_clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < edge_cnt) begin
            e = sb.pop_front();
            chk("missed_grant", '0, 128'(e.grant));
        end
        if (sb.size() > 0 && sb[0].cyc == edge_cnt) begin
            e = sb.pop_front();
            chk("grant", 128'(bus.parser_valid), 128'(e.grant));
            chk("tag", 128'(bus.parser_tag), 128'(e.tag));
            chk("tuser", bus.parser_tuser, e.tuser);
            n_cmp++;
            if (bus.parser_segs !== e.segs) begin
                n_err++;
                $display("FAIL segs: got[63:0] %0h expected[63:0] %0h (t=%0t)",
                         bus.parser_segs[63:0], e.segs[63:0], $time);
            end
        end else chk("no_grant", 128'(bus.parser_valid), '0);
        chk("fifo_count", 128'(fifo_count), 128'(mq.size()));
        chk("drop_cnt", 128'(drop_cnt), 128'(m_drops));
    end

    // Engine emulation: busy rises the cycle after a grant is seen.
    int            bcnt[NP];
    bit            pend[NP];
    logic [NP-1:0] force_busy = '0;
    int            busy_len = 3;

    always @(negedge axis_clk) begin
        for (int i = 0; i < NP; i++) begin
            if (bcnt[i] > 0) bcnt[i]--;
            if (pend[i]) begin
                bcnt[i] = (busy_len == 0) ? int'($urandom_range(1, 4)) : busy_len;
                pend[i] = 1'b0;
            end
            if (bus.parser_valid[i]) pend[i] = 1'b1;
            bus.parser_busy[i] = (bcnt[i] > 0) || force_busy[i];
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge axis_clk);
    endtask

    task automatic pulse();
        for (int w = 0; w < SW / 32; w++) bus.segs_in[w*32 +: 32] = $urandom();
        for (int w = 0; w < TW / 32; w++) bus.tuser_in[w*32 +: 32] = $urandom();
        bus.segs_valid_in = 1'b1;
        @(negedge axis_clk);
        bus.segs_valid_in = 1'b0;
    endtask

    initial begin
        bus.segs_in = '0;
        bus.tuser_in = '0;
        bus.segs_valid_in = 1'b0;
        idle(3);
        chk("rst_valid", 128'(bus.parser_valid), '0);
        chk("rst_tag", 128'(bus.parser_tag), '0);
        chk("rst_segs_or", 128'(|bus.parser_segs), '0);
        chk("rst_tuser", bus.parser_tuser, '0);
        chk("rst_count", 128'(fifo_count), '0);
        chk("rst_drop", 128'(drop_cnt), '0);

        aresetn = 1'b1;
        dispatch_en = 1'b1;
        idle(6);
        pulse();                       // single bundle, latency checked by cycle stamp
        idle(6);
        repeat (4) pulse();            // back-to-back, alternating grants
        idle(12);

        dispatch_en = 1'b0;            // overflow with dispatch held off
        repeat (6) pulse();
        idle(2);
        chk("hold_count", 128'(fifo_count), 128'(D));
        chk("hold_drop", 128'(drop_cnt), 128'd2);
        dispatch_en = 1'b1;
        idle(12);

        dispatch_en = 1'b0;            // full FIFO + simultaneous pop and write
        repeat (4) pulse();
        force_busy = 2'b10;
        idle(2);
        dispatch_en = 1'b1;
        pulse();
        chk("fullpop_count", 128'(fifo_count), 128'(D));
        chk("fullpop_drop", 128'(drop_cnt), 128'd2);
        force_busy = '0;
        idle(15);

        busy_len = 0;                  // random traffic, several tag wraps
        for (int c = 0; c < 1500; c++) begin
            if (c % 300 == 150) force_busy = '1;
            if (c % 300 == 160) force_busy = '0;
            dispatch_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1) pulse();
            else idle(1);
        end
        dispatch_en = 1'b1;
        busy_len = 3;
        idle(20);

        dispatch_en = 1'b0;            // reset with bundles queued and a grant in flight
        repeat (3) pulse();
        dispatch_en = 1'b1;
        idle(1);
        aresetn = 1'b0;
        idle(1);
        chk("midrst_valid", 128'(bus.parser_valid), '0);
        chk("midrst_count", 128'(fifo_count), '0);
        chk("midrst_drop", 128'(drop_cnt), '0);
        aresetn = 1'b1;
        idle(5);
        pulse();                       // expected tag 0 from the model
        idle(10);

        chk("sb_drain", 128'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
